// File: rtl/fetch_stream_if.sv
// ============================================================================
// fetch_stream_if : memory-port and decode-side signals of the fetch unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface fetch_stream_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic          mem_gnt;
  logic          mem_ready;
  logic [DW-1:0] mem_data_out;
  logic          ib_valid;
  logic [DW-1:0] ib_data;
  logic [AW-1:0] ib_pc;
  logic          ib_pop;
  logic          branch_taken;
  logic [AW-1:0] branch_target;

  modport master (
    output mem_re, mem_raddr, ib_valid, ib_data, ib_pc,
    input  mem_gnt, mem_ready, mem_data_out, ib_pop, branch_taken, branch_target
  );

  modport slave (
    input  mem_re, mem_raddr, ib_valid, ib_data, ib_pc,
    output mem_gnt, mem_ready, mem_data_out, ib_pop, branch_taken, branch_target
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stream.sv
// ============================================================================
// fetch_stream : sequential instruction fetch with outstanding reads and buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_stream #(
  parameter int            AW       = 16,
  parameter int            DW       = 16,
  parameter int            DEPTH    = 4,
  parameter int            MAX_OUT  = 2,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_stream_if.master bus
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_out_w = $clog2(MAX_OUT + 1);
  localparam int c_fp_w  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [AW-1:0]      r_pc;
  logic [c_out_w-1:0] r_inflight;
  logic [c_out_w-1:0] r_drop;
  logic [c_cnt_w-1:0] r_count;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_fp_w-1:0]  r_fifo_rd;
  logic [c_fp_w-1:0]  r_fifo_wr;

  logic [AW-1:0]      r_buf_pc   [DEPTH];
  logic [DW-1:0]      r_buf_data [DEPTH];
  logic [AW-1:0]      r_fifo_pc  [MAX_OUT];

  logic [31:0]        w_occupancy;
  logic               w_can_issue;
  logic               w_issue;
  logic               w_resp;
  logic               w_discard;
  logic               w_push;
  logic               w_pop;
  logic [AW-1:0]      w_resp_pc;
  logic [c_out_w-1:0] w_inflight_nxt;

  function automatic logic [c_fp_w-1:0] fp_next(input logic [c_fp_w-1:0] p);
    return (p == c_fp_w'(MAX_OUT - 1)) ? '0 : p + c_fp_w'(1);
  endfunction

  // Responses owed to a dead path still hold a credit until they return,
  // so they are subtracted out: each kept response is guaranteed a slot.
  assign w_occupancy = 32'(r_count) + 32'(r_inflight) - 32'(r_drop);
  assign w_can_issue = !bus.branch_taken
                    && (32'(r_inflight) < 32'(MAX_OUT))
                    && (w_occupancy < 32'(DEPTH));

  assign bus.mem_re    = rst_n && w_can_issue;
  assign bus.mem_raddr = r_pc;

  assign w_issue   = bus.mem_re && bus.mem_gnt;
  assign w_resp    = bus.mem_ready && (r_inflight != '0);
  assign w_discard = (r_drop != '0) || bus.branch_taken;
  assign w_push    = w_resp && !w_discard;
  assign w_pop     = (r_count != '0) && bus.ib_pop && !bus.branch_taken;
  assign w_resp_pc = r_fifo_pc[r_fifo_rd];

  assign w_inflight_nxt = r_inflight + c_out_w'(w_issue) - c_out_w'(w_resp);

  assign bus.ib_valid = (r_count != '0);
  assign bus.ib_data  = r_buf_data[r_rd_ptr];
  assign bus.ib_pc    = r_buf_pc[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fifo_rd  <= '0;
      r_fifo_wr  <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      if (w_issue) begin
        r_pc      <= r_pc + AW'(1);
        r_fifo_wr <= fp_next(r_fifo_wr);
      end
      if (w_resp) begin
        r_fifo_rd <= fp_next(r_fifo_rd);
      end
      if (bus.branch_taken) begin
        r_pc     <= bus.branch_target;
        r_drop   <= w_inflight_nxt;
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_resp && (r_drop != '0)) begin
          r_drop <= r_drop - c_out_w'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + c_cnt_w'(1);
        end else if (!w_push && w_pop) begin
          r_count <= r_count - c_cnt_w'(1);
        end
      end
    end
  end

  // Storage arrays carry no reset; their contents are only read once valid.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_fifo_pc[r_fifo_wr] <= r_pc;
    end
    if (w_push) begin
      r_buf_pc[r_wr_ptr]   <= w_resp_pc;
      r_buf_data[r_wr_ptr] <= bus.mem_data_out;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stream.sv
// ============================================================================
// tb_fetch_stream : directed self-checking bench for fetch_stream
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stream;

  localparam int AW = 16;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_stream_if #(.AW(AW), .DW(DW)) bus ();

  fetch_stream #(
    .AW(AW), .DW(DW), .DEPTH(4), .MAX_OUT(2), .RESET_PC(16'hFFFE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          inj_ready;
  logic [DW-1:0] inj_data;

  assign bus.mem_ready    = m_ready | inj_ready;
  assign bus.mem_data_out = inj_ready ? inj_data : m_data;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } req_t;

  req_t q[$];
  int   cyc = 0;
  int   lat = 1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [AW-1:0] exp_pc;

  // In-order memory: returns addr+0x100 exactly lat cycles after issue.
  initial begin
    m_ready = 1'b0;
    m_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
      end else begin
        if (m_ready && q.size() > 0) q.delete(0);
        if (bus.mem_re && bus.mem_gnt) q.push_back('{bus.mem_raddr, cyc + lat});
      end
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0 && q[0].due <= cyc) begin
        m_ready = 1'b1;
        m_data  = DW'(q[0].addr + 16'h0100);
      end else begin
        m_ready = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    bus.mem_gnt       = 1'b1;
    bus.ib_pop        = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    inj_ready         = 1'b0;
    inj_data          = '0;

    repeat (3) @(posedge clk);
    mid();
    check("rst_mem_re", 32'(bus.mem_re), 0);
    check("rst_ib_valid", 32'(bus.ib_valid), 0);

    // stream from RESET_PC with wrap, 1-cycle memory
    tick(); rst_n = 1'b1; bus.ib_pop = 1'b1; mid();           // c1
    check("c1_mem_re", 32'(bus.mem_re), 1);
    check("c1_raddr", 32'(bus.mem_raddr), 32'hFFFE);
    check("c1_ib_valid", 32'(bus.ib_valid), 0);
    tick(); mid();                                            // c2
    check("c2_ib_valid", 32'(bus.ib_valid), 0);
    check("c2_raddr", 32'(bus.mem_raddr), 32'hFFFF);
    for (int k = 0; k < 4; k++) begin                         // c3..c6
      tick(); mid();
      exp_pc = 16'hFFFE + 16'(k);
      check("stream_valid", 32'(bus.ib_valid), 1);
      check("stream_pc", 32'(bus.ib_pc), 32'(exp_pc));
      check("stream_data", 32'(bus.ib_data), 32'(16'(exp_pc + 16'h0100)));
    end

    // stall decode: buffer fills to DEPTH, issue stops
    tick(); bus.ib_pop = 1'b0; mid();                         // c7
    repeat (5) begin tick(); mid(); end                       // c8..c12
    check("full_ib_pc", 32'(bus.ib_pc), 32'h0002);
    check("full_ib_data", 32'(bus.ib_data), 32'h0102);
    check("full_mem_re", 32'(bus.mem_re), 0);
    tick(); bus.ib_pop = 1'b1; mid();                         // c13
    check("pop1_ib_pc", 32'(bus.ib_pc), 32'h0002);
    tick(); bus.ib_pop = 1'b0; mid();                         // c14
    check("reissue_mem_re", 32'(bus.mem_re), 1);
    check("reissue_raddr", 32'(bus.mem_raddr), 32'h0006);
    check("reissue_ib_pc", 32'(bus.ib_pc), 32'h0003);
    tick(); mid();                                            // c15
    check("refull_mem_re", 32'(bus.mem_re), 0);

    // 3-cycle memory, redirect with two reads in flight
    tick(); lat = 3; mid();                                   // c16
    tick(); bus.ib_pop = 1'b1; mid();                         // c17
    tick(); mid();                                            // c18
    tick(); mid();                                            // c19
    tick(); bus.ib_pop = 1'b0; bus.branch_taken = 1'b1; bus.branch_target = 16'h0040; mid(); // c20
    check("br_mem_re", 32'(bus.mem_re), 0);
    check("br_ib_pc", 32'(bus.ib_pc), 32'h0006);
    tick(); bus.branch_taken = 1'b0; mid();                   // c21
    check("br_flush_valid", 32'(bus.ib_valid), 0);
    check("br_full_out_re", 32'(bus.mem_re), 0);
    tick(); mid();                                            // c22
    check("br_tgt_re", 32'(bus.mem_re), 1);
    check("br_tgt_raddr", 32'(bus.mem_raddr), 32'h0040);
    tick(); mid();                                            // c23
    check("br_tgt_raddr2", 32'(bus.mem_raddr), 32'h0041);
    tick(); mid();                                            // c24
    tick(); mid();                                            // c25
    check("br_stale_drop", 32'(bus.ib_valid), 0);
    tick(); mid();                                            // c26
    check("br_new_valid", 32'(bus.ib_valid), 1);
    check("br_new_pc", 32'(bus.ib_pc), 32'h0040);
    check("br_new_data", 32'(bus.ib_data), 32'h0140);

    // redirect coinciding with a response and a pop
    tick(); mid();                                            // c27
    tick(); mid();                                            // c28
    tick(); bus.ib_pop = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 16'h0100; mid(); // c29
    check("br2_ib_pc", 32'(bus.ib_pc), 32'h0040);
    check("br2_mem_re", 32'(bus.mem_re), 0);
    tick(); bus.ib_pop = 1'b0; bus.branch_taken = 1'b0; mid(); // c30
    check("br2_flush_valid", 32'(bus.ib_valid), 0);
    check("br2_tgt_re", 32'(bus.mem_re), 1);
    check("br2_tgt_raddr", 32'(bus.mem_raddr), 32'h0100);
    tick(); mid();                                            // c31
    check("br2_tgt_raddr2", 32'(bus.mem_raddr), 32'h0101);
    tick(); mid();                                            // c32
    tick(); mid();                                            // c33
    check("br2_stale_drop", 32'(bus.ib_valid), 0);
    tick(); bus.ib_pop = 1'b1; mid();                         // c34
    check("br2_new_pc", 32'(bus.ib_pc), 32'h0100);
    check("br2_new_data", 32'(bus.ib_data), 32'h0200);
    tick(); bus.ib_pop = 1'b0; mid();                         // c35
    check("br2_next_pc", 32'(bus.ib_pc), 32'h0101);
    check("br2_next_data", 32'(bus.ib_data), 32'h0201);

    // reset mid-stream with two reads in flight
    tick(); rst_n = 1'b0; mid();                              // c36
    check("mrst_mem_re", 32'(bus.mem_re), 0);
    check("mrst_ib_valid", 32'(bus.ib_valid), 0);
    tick(); mid();                                            // c37
    tick(); rst_n = 1'b1; bus.mem_gnt = 1'b0; lat = 1;
    inj_ready = 1'b1; inj_data = 16'hDEAD; mid();             // c38
    check("rel_mem_re", 32'(bus.mem_re), 1);
    check("rel_raddr", 32'(bus.mem_raddr), 32'hFFFE);
    tick(); inj_ready = 1'b0; mid();                          // c39
    check("stray_ignored", 32'(bus.ib_valid), 0);
    check("nognt_hold_re", 32'(bus.mem_re), 1);
    check("nognt_hold_raddr", 32'(bus.mem_raddr), 32'hFFFE);
    tick(); bus.mem_gnt = 1'b1; bus.ib_pop = 1'b1; mid();     // c40
    tick(); mid();                                            // c41
    tick(); mid();                                            // c42
    check("restart_valid", 32'(bus.ib_valid), 1);
    check("restart_pc", 32'(bus.ib_pc), 32'hFFFE);
    check("restart_data", 32'(bus.ib_data), 32'h00FE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
